// File: rtl/hash_stream_ctrl_pkg.sv
// hash_stream_ctrl_pkg: shared defaults and FSM state encoding for the hash stream controller
package hash_stream_ctrl_pkg;
    localparam int WORD_W_DEF = 8;
    localparam int OUT_W_DEF  = 32;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_ABSORB = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
endpackage

// File: rtl/hash_word_serializer.sv
// hash_word_serializer: holding + shift register turning message words into one bit per cycle, MSB first
//   clr      : empty both registers and zero the accepted-word count
//   window   : words may be accepted this cycle
//   shift_en : a message bit is due this cycle
//   len      : message length in words; in_valid/in_data/in_ready : word handshake
//   tx_bit   : bit for the injector; miss : a word slot started with no data available
module hash_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              window,
    input  logic              shift_en,
    input  logic [15:0]       len,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              miss
);
    localparam int BW = $clog2(WORD_W + 1);
    logic [WORD_W-1:0] hold, sr, src;
    logic              hold_full, xfer, take, have;
    logic [BW-1:0]     bits;
    logic [15:0]       acc;
    // a word arriving while both registers are empty goes straight into the shift register
    always_comb begin
        in_ready = window && !hold_full && acc < len;
        xfer     = in_valid && in_ready;
        take     = shift_en && bits == '0;
        have     = hold_full || xfer;
        src      = hold_full ? hold : in_data;
        miss     = take && !have;
        tx_bit   = shift_en && (take ? have && src[WORD_W-1] : sr[WORD_W-1]);
    end
    // a missed slot still occupies WORD_W zero bits and counts as a consumed word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            sr        <= '0;
            hold_full <= 1'b0;
            bits      <= '0;
            acc       <= '0;
        end else if (clr) begin
            hold      <= '0;
            sr        <= '0;
            hold_full <= 1'b0;
            bits      <= '0;
            acc       <= '0;
        end else begin
            if (take) begin
                sr   <= have ? src << 1 : '0;
                bits <= BW'(WORD_W - 1);
            end else if (shift_en) begin
                sr   <= sr << 1;
                bits <= bits - BW'(1);
            end
            if (take) hold_full <= 1'b0;
            else if (xfer) begin
                hold_full <= 1'b1;
                hold      <= in_data;
            end
            if (xfer || miss) acc <= acc + 16'd1;
        end
    end
endmodule

// File: rtl/hash_stream_ctrl.sv
// hash_stream_ctrl: sequences a serial hash core through clear, warm-up, absorb and flush, then captures the digest
//   start/msg_len      : begin a hash of msg_len words (sampled in IDLE)
//   in_valid/in_data/in_ready : message word handshake
//   hash_rst/injector/hash_o  : hash core reset, serial input bit and output
//   digest/digest_valid       : captured result and its one-cycle update pulse
//   underflow/busy            : missed-data flag for the current hash, not-IDLE indicator
module hash_stream_ctrl import hash_stream_ctrl_pkg::*; #(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int CLR_CYC = 2,
    parameter int WARMUP  = 16,
    parameter int FLUSH   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       msg_len,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              hash_rst,
    output logic              injector,
    input  logic [OUT_W-1:0]  hash_o,
    output logic [OUT_W-1:0]  digest,
    output logic              digest_valid,
    output logic              underflow,
    output logic              busy
);
    localparam int TOT = 65535 * WORD_W;
    localparam int M1  = TOT > FLUSH ? TOT : FLUSH;
    localparam int M2  = M1 > WARMUP ? M1 : WARMUP;
    localparam int M3  = M2 > CLR_CYC ? M2 : CLR_CYC;
    localparam int CW  = $clog2(M3 + 1);
    logic [2:0]    state;
    logic [CW-1:0] cnt, plen;
    logic [15:0]   len;
    logic          last, miss;
    // one phase counter, compared against the length of whichever phase is active
    always_comb begin
        plen     = state == S_CLEAR ? CW'(CLR_CYC) : state == S_WARMUP ? CW'(WARMUP) :
                   state == S_ABSORB ? CW'(len) * CW'(WORD_W) : CW'(FLUSH);
        last     = cnt == plen - CW'(1);
        busy     = state != S_IDLE;
        hash_rst = !reset || state == S_CLEAR;
    end
    hash_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk(clk),
        .reset(reset),
        .clr(state == S_CLEAR),
        .window(state == S_WARMUP || state == S_ABSORB),
        .shift_en(state == S_ABSORB),
        .len(len),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .tx_bit(injector),
        .miss(miss)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            len          <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            digest_valid <= state == S_DONE;
            if (state == S_DONE) digest <= hash_o;
            if (miss) underflow <= 1'b1;
            cnt <= (state == S_IDLE || state == S_DONE || last) ? '0 : cnt + CW'(1);
            case (state)
                S_IDLE: if (start) begin
                    len       <= msg_len;
                    underflow <= 1'b0;
                    state     <= S_CLEAR;
                end
                S_CLEAR:  if (last) state <= S_WARMUP;
                S_WARMUP: if (last) state <= len == 16'd0 ? S_FLUSH : S_ABSORB;
                S_ABSORB: if (last) state <= S_FLUSH;
                S_FLUSH:  if (last) state <= S_DONE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_stream_ctrl.sv
// tb_hash_stream_ctrl: randomized self-checking bench with a word-slot reference model and a stand-in hash core
module tb_hash_stream_ctrl;
    localparam int W = 8, OW = 32, CLR = 2, WU = 16, FL = 64, A = 1 + CLR + WU, LIM = 600;
    logic clk = 0, reset = 1, start = 0, in_valid = 0;
    logic [15:0] msg_len = 0;
    logic [W-1:0] in_data = 0;
    logic in_ready, hash_rst, injector, digest_valid, underflow, busy;
    logic [OW-1:0] hash_o, digest;
    int checks = 0, errors = 0;
    logic [W-1:0] words[$];
    int gap_at = 0, gap_len = 0, extra_at = -1, abort_at = -10;
    int lat, rdy_cnt, exp_lat;
    int hs_t[$];
    logic [W-1:0] hs_w[$];
    logic inj[0:LIM-1];
    logic uf, exp_uf;
    logic [OW-1:0] dig, exp_dig, dig1;
    logic exp_bits[$];

    hash_stream_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .hash_rst(hash_rst), .injector(injector), .hash_o(hash_o),
        .digest(digest), .digest_valid(digest_valid), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] core_step(logic [OW-1:0] o, logic b);
        return {o[OW-2:0], o[31] ^ o[21] ^ o[1] ^ o[0] ^ b};
    endfunction

    always @(posedge clk) hash_o <= hash_rst ? '0 : core_step(hash_o, injector);

    task automatic run_hash(input int len);
        int wi;
        wi = 0; lat = -1; rdy_cnt = 0; uf = 0; dig = '0;
        hs_t.delete(); hs_w.delete();
        @(negedge clk);
        msg_len = 16'(len);
        for (int c = 0; c < LIM; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0) || (c == extra_at);
            in_valid = wi < words.size() && !(c >= gap_at && c < gap_at + gap_len);
            in_data = in_valid ? words[wi] : W'($urandom);
            if (c == abort_at) reset = 0;
            if (c == abort_at + 2) reset = 1;
            #1;
            inj[c] = injector;
            rdy_cnt += int'(in_ready);
            if (in_valid && in_ready) begin
                hs_t.push_back(c);
                hs_w.push_back(in_data);
                wi++;
            end
            if (digest_valid) begin
                lat = c; uf = underflow; dig = digest;
                break;
            end
        end
        start = 0; in_valid = 0;
    endtask

    // slot k opens at absorb cycle k*W and takes the oldest word accepted by then, else zeros
    task automatic build_model(input int len);
        int qi;
        logic [OW-1:0] o;
        logic [W-1:0] w;
        exp_bits.delete(); exp_uf = 0; qi = 0; o = '0;
        for (int k = 0; k < len; k++) begin
            if (qi < hs_t.size() && hs_t[qi] <= A + k * W) begin
                w = hs_w[qi]; qi++;
            end else begin
                w = '0; exp_uf = 1;
            end
            for (int b = W - 1; b >= 0; b--) exp_bits.push_back(w[b]);
        end
        for (int i = 0; i < WU; i++) o = core_step(o, 1'b0);
        foreach (exp_bits[i]) o = core_step(o, exp_bits[i]);
        for (int i = 0; i < FL; i++) o = core_step(o, 1'b0);
        exp_dig = o;
        exp_lat = 1 + CLR + WU + len * W + FL + 1;
    endtask

    function automatic int first_bad(int len);
        for (int c = 1; c < lat; c++)
            if (inj[c] !== ((c >= A && c < A + len * W) ? exp_bits[c - A] : 1'b0)) return c;
        return -1;
    endfunction

    task automatic load_random(input int len);
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(W'($urandom));
    endtask

    task automatic test_reset;
        #2 reset = 0;
        #12;
        checks++; if (hash_rst !== 1'b1) begin errors++; $display("FAIL reset_hash_rst: got %b expected 1", hash_rst); end
        checks++; if (digest !== '0) begin errors++; $display("FAIL reset_digest: got %h expected 0", digest); end
        checks++; if ({busy, in_ready, injector, digest_valid, underflow} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: busy/in_ready/injector/dv/uf got %b expected 00000",
                               {busy, in_ready, injector, digest_valid, underflow});
        end
        @(negedge clk) reset = 1;
        @(negedge clk); #1;
        checks++; if ({busy, hash_rst, in_ready} !== 3'b0) begin
            errors++; $display("FAIL reset_release: busy/hash_rst/in_ready got %b expected 000", {busy, hash_rst, in_ready});
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] v[3] = '{8'hA5, 8'h3C, 8'hFF};
        words.delete();
        foreach (v[i]) words.push_back(v[i]);
        run_hash(3); build_model(3);
        checks++; if (lat !== 108) begin errors++; $display("FAIL directed_latency: got %0d expected 108", lat); end
        checks++; if (hs_t.size() !== 3) begin errors++; $display("FAIL directed_accepts: got %0d expected 3", hs_t.size()); end
        checks++; if (first_bad(3) !== -1) begin errors++; $display("FAIL directed_stream: bad cycle %0d expected none", first_bad(3)); end
        checks++; if (uf !== 1'b0) begin errors++; $display("FAIL directed_underflow: got %b expected 0", uf); end
        checks++; if (dig !== exp_dig) begin errors++; $display("FAIL directed_digest: got %h expected %h", dig, exp_dig); end
    endtask

    task automatic test_zero_len;
        words.delete();
        run_hash(0); build_model(0);
        checks++; if (lat !== 84) begin errors++; $display("FAIL zero_latency: got %0d expected 84", lat); end
        checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL zero_in_ready: got %0d pulses expected 0", rdy_cnt); end
        checks++; if (first_bad(0) !== -1) begin errors++; $display("FAIL zero_stream: bad cycle %0d expected none", first_bad(0)); end
        checks++; if (dig !== exp_dig) begin errors++; $display("FAIL zero_digest: got %h expected %h", dig, exp_dig); end
    endtask

    task automatic test_underflow;
        load_random(5);
        gap_at = 36; gap_len = 10;
        run_hash(5); build_model(5);
        gap_len = 0;
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL uf_latency: got %0d expected %0d", lat, exp_lat); end
        checks++; if (uf !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b expected 1", uf); end
        checks++; if (first_bad(5) !== -1) begin errors++; $display("FAIL uf_stream: bad cycle %0d expected none", first_bad(5)); end
        checks++; if (dig !== exp_dig) begin errors++; $display("FAIL uf_digest: got %h expected %h", dig, exp_dig); end
    endtask

    task automatic test_random;
        int len;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 8);
            load_random(len);
            gap_at = $urandom_range(0, 90); gap_len = $urandom_range(0, 20);
            run_hash(len); build_model(len);
            gap_len = 0;
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, lat, exp_lat); end
            checks++; if (hs_t.size() > len) begin errors++; $display("FAIL rand%0d_accepts: got %0d expected <= %0d", r, hs_t.size(), len); end
            checks++; if (first_bad(len) !== -1) begin errors++; $display("FAIL rand%0d_stream: bad cycle %0d expected none", r, first_bad(len)); end
            checks++; if (uf !== exp_uf) begin errors++; $display("FAIL rand%0d_underflow: got %b expected %b", r, uf, exp_uf); end
            checks++; if (dig !== exp_dig) begin errors++; $display("FAIL rand%0d_digest: got %h expected %h", r, dig, exp_dig); end
        end
    endtask

    task automatic test_busy_start;
        int n;
        load_random(2);
        extra_at = 40;
        run_hash(2); build_model(2);
        extra_at = -1;
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, exp_lat); end
        n = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk); #1;
            n += int'(digest_valid || busy);
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL busy_start_second_hash: got %0d active cycles expected 0", n); end
    endtask

    task automatic test_abort;
        load_random(4);
        abort_at = 25;
        run_hash(4);
        abort_at = -10;
        checks++; if (lat !== -1) begin errors++; $display("FAIL abort_digest_valid: seen at cycle %0d expected none", lat); end
        checks++; if ({busy, hash_rst, digest_valid} !== 3'b0) begin
            errors++; $display("FAIL abort_idle: busy/hash_rst/dv got %b expected 000", {busy, hash_rst, digest_valid});
        end
    endtask

    task automatic test_back_to_back;
        load_random(4);
        run_hash(4); build_model(4);
        dig1 = dig;
        run_hash(4);
        checks++; if (dig1 !== exp_dig) begin errors++; $display("FAIL b2b_first_digest: got %h expected %h", dig1, exp_dig); end
        checks++; if (dig !== dig1) begin errors++; $display("FAIL b2b_repeat_digest: got %h expected %h", dig, dig1); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_zero_len;
        test_underflow;
        test_random;
        test_busy_start;
        test_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_stream_ctrl.md
HASH_STREAM_CTRL -- requirements
Module: hash_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8: message word width in bits.
REQ-002 SHALL have parameter OUT_W, default 32: hash core output width (equals the hash core output LFSR size).
REQ-003 SHALL have parameter CLR_CYC, default 2: number of cycles hash_rst is held.
REQ-004 SHALL have parameter WARMUP, default 16: zero-injection cycles before the first message bit.
REQ-005 SHALL have parameter FLUSH, default 64: zero-injection cycles after the last message bit.
REQ-006 SHALL have port clk, input, 1: single clock; the block and the hash core share this clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: begin a hash; sampled only in IDLE.
REQ-009 SHALL have port msg_len, input, 16: message length in words; sampled with start.
REQ-010 SHALL have port in_valid, input, 1: in_data is valid.
REQ-011 SHALL have port in_data, input, WORD_W: message word.
REQ-012 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-013 SHALL have port hash_rst, output, 1: active-high reset to the hash core.
REQ-014 SHALL have port injector, output, 1: serial bit to the hash core input injector.
REQ-015 SHALL have port hash_o, input, OUT_W: hash core output O.
REQ-016 SHALL have port digest, output, OUT_W: captured hash result.
REQ-017 SHALL have port digest_valid, output, 1: one-cycle pulse when digest updates.
REQ-018 SHALL have port underflow, output, 1: sticky flag for the current hash; in_data was missing when a bit was due.
REQ-019 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, WARMUP, ABSORB, FLUSH and DONE.
REQ-021 In IDLE, start=1 SHALL latch msg_len, clear underflow, and move to CLEAR.
REQ-022 hash_rst SHALL be 1 for exactly CLR_CYC cycles in CLEAR and 0 in every other state; CLEAR SHALL then go to WARMUP.
REQ-023 WARMUP SHALL drive injector=0 for WARMUP cycles, then go to ABSORB, or to FLUSH if msg_len=0.
REQ-024 Datapath: a holding register plus a shift register, each WORD_W wide; words are transmitted MSB first, one bit per cycle.
REQ-025 in_ready SHALL be 1 only in WARMUP or ABSORB, when the holding register is empty and the count of accepted words is less than msg_len.
REQ-026 A word SHALL be transferred when in_valid and in_ready are both 1; that word is then held until it is loaded.
REQ-027 In ABSORB, when the shift register empties, it SHALL load from the holding register in the same cycle, so that a continuously fed stream has no bubble between words.
REQ-028 If a bit is due and both registers are empty, the block SHALL inject 0, set underflow, and still count that bit as sent, so total ABSORB length is always msg_len*WORD_W cycles.
REQ-029 On underflow, the missed word SHALL be skipped: accepted-word count advances as if consumed.
REQ-030 After the last bit, the block SHALL go to FLUSH, drive injector=0 for FLUSH cycles, then go to DONE.
REQ-031 In DONE, the block SHALL capture hash_o into digest, pulse digest_valid for 1 cycle, and return to IDLE the next cycle.
REQ-032 start SHALL be ignored when busy=1.
REQ-033 in_valid SHALL be ignored outside WARMUP and ABSORB.
REQ-034 digest SHALL hold its value until the next DONE.
REQ-035 Latency from start to digest_valid SHALL be 1+CLR_CYC+WARMUP+msg_len*WORD_W+FLUSH+1 cycles.
REQ-036 All counters SHALL be sized to their maximum values; msg_len=65535 SHALL not wrap.

Reset
REQ-037 When reset=0, the block SHALL force: state=IDLE, busy=0, in_ready=0, hash_rst=1, injector=0, digest=0, digest_valid=0, underflow=0, and all counters and registers 0.
REQ-038 Reset asserted mid-hash SHALL abort the hash with no digest_valid; after reset release the block is in IDLE.

Structure
REQ-039 A shared package SHALL hold the state enumeration and the WORD_W/OUT_W defaults.
REQ-040 A sub-module hash_word_serializer (holding register, shift register, bit counter) is natural; the FSM stays in the top level.

Verification
REQ-041 Reset check: reset=0 -> hash_rst=1, digest=0, busy=0; after release, IDLE with hash_rst=0.
REQ-042 Fully fed msg_len=3 (0xA5, 0x3C, 0xFF) -> injector carries 24 bits MSB first after 16 warm-up zeros; digest_valid at cycle 1+2+16+24+64+1=108; underflow=0.
REQ-043 msg_len=0 -> no in_ready pulses; digest_valid at cycle 84.
REQ-044 in_valid withheld for 10 cycles mid-message -> underflow=1, zero bits injected, digest_valid timing unchanged.
REQ-045 start pulsed while busy, and reset dropped during ABSORB -> no second hash, no digest_valid, IDLE after release.
REQ-046 Two identical back-to-back hashes -> identical digest values.
